stream_sel_skid: RTL

//  Parametrised N-way stream selector for the video path. It replaces the fixed 2-input camera/SA mux.
//  - Adds full valid/ready handshaking, per-channel width zero-extension and packet-safe switching.

---
 rtl/stream_pkg.sv | 11 +
 rtl/stream_skid_buf.sv | 43 ++++
 rtl/stream_sel_skid.sv | 71 +++++++
 3 files changed

// File: rtl/stream_pkg.sv
// stream_pkg: shared FSM state type and width helpers for the stream selector
package stream_pkg;
  typedef enum logic {ST_BOUNDARY, ST_IN_PKT} sel_state_t;
  localparam int MAX_W = 64;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [MAX_W-1:0] zext(input logic [MAX_W-1:0] d, input int in_w);
    return d & ((MAX_W'(1) << in_w) - MAX_W'(1));
  endfunction
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry register slice with registered input ready
module stream_skid_buf #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, push, take;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  assign push = s_valid_i & rdy_q;
  assign take = !main_v_q | m_ready_i;
  // ready is only high while the skid slot is free, so push never coincides with a skid reload
  always_comb begin
    main_v_d = take ? (skid_v_q | push) : main_v_q;
    main_d   = take ? (skid_v_q ? skid_q : (push ? s_data_i : main_q)) : main_q;
    skid_v_d = take ? 1'b0 : (skid_v_q | push);
    skid_d   = (!take && push) ? s_data_i : skid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= !skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end
  assign s_ready_o = rdy_q;
  assign m_valid_o = main_v_q;
  assign m_data_o  = main_q;
endmodule

// File: rtl/stream_sel_skid.sv
// stream_sel_skid: N-way packet-safe stream selector with zero-extension and skid-buffered output
module stream_sel_skid
  import stream_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 16,
  parameter bit DROP_UNSEL = 1'b1,
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_W-1:0]        sel,
  input  logic [NUM_CH-1:0]      s_tvalid,
  input  logic [NUM_CH*IN_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]      s_tlast,
  output logic [NUM_CH-1:0]      s_tready,
  output logic                   m_tvalid,
  output logic [OUT_W-1:0]       m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [CH_W-1:0]        active_ch,
  output logic                   sw_pending
);
  sel_state_t state_q, state_d;
  logic [CH_W-1:0] active_q, active_d;
  logic run_q, sel_ok, bubble, buf_v, buf_rdy, acc, beat_last;
  logic [IN_W-1:0] beat_data;
  logic [OUT_W:0] buf_out;
  assign sel_ok     = int'(sel) < NUM_CH;
  assign bubble     = state_q == ST_BOUNDARY && sel_ok && sel != active_q;
  assign sw_pending = state_q == ST_IN_PKT && sel_ok && sel != active_q;
  assign beat_data  = s_tdata[active_q*IN_W +: IN_W];
  assign beat_last  = s_tlast[active_q];
  assign buf_v      = s_tvalid[active_q] & !bubble;
  assign acc        = buf_v & buf_rdy;
  always_comb begin
    active_d = bubble ? sel : active_q;
    state_d  = (!bubble && acc) ? (beat_last ? ST_BOUNDARY : ST_IN_PKT) : state_q;
  end
  // run_q keeps every ready low until the first edge after reset release
  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_CH; i++)
      s_tready[i] = run_q && ((i == int'(active_q) && !bubble) ? buf_rdy : DROP_UNSEL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOUNDARY;
      active_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      run_q    <= 1'b1;
    end
  end
  stream_skid_buf #(.W(OUT_W + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid_i (buf_v),
    .s_ready_o (buf_rdy),
    .s_data_i  ({beat_last, OUT_W'(zext(MAX_W'(beat_data), IN_W))}),
    .m_valid_o (m_tvalid),
    .m_ready_i (m_tready),
    .m_data_o  (buf_out)
  );
  assign m_tdata   = buf_out[OUT_W-1:0];
  assign m_tlast   = buf_out[OUT_W];
  assign active_ch = active_q;
endmodule
